// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter that drives a 3-to-8 decoder.
package decoder_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Round-robin pick: the first set request searching upward from last_id+1, wrapping 7 -> 0.
    // Result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last_id);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int i = N_REQ; i >= 1; i--) begin
            idx = last_id + IDX_W'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_decoder_3_8.sv
// Existing 3-to-8 decoder with enable; the arbiter's one-hot grant comes only from here.
module decoder_3_8 (
    input  logic       E,
    input  logic [2:0] In,
    output logic [7:0] Out
);

    // One-hot decode of In when enabled, all zeros otherwise.
    always_comb begin
        Out = 8'b0;
        if (E) Out = 8'b1 << In;
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters; the grant is produced by a 3-to-8 decoder
// fed from registered enable/select. One dead cycle separates consecutive grants.
// Optional macro ARB_TIMEOUT_EN: force release after MAX_TENURE grant cycles when
// another requester is waiting.
//
//  state | meaning
//  IDLE  | no grant; pick the round-robin winner from req
//  GRANT | decoder enabled for gnt_id until its request drops (or tenure expires)
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int MAX_TENURE = 15,
    parameter int TEN_W      = 8
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             dec_e,
    output logic [IDX_W-1:0] dec_in,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_id
);

    if (MAX_TENURE < 1 || MAX_TENURE > 255 || MAX_TENURE >= (1 << TEN_W)) begin : g_bad_cfg
        $error("decoder_rr_arbiter: MAX_TENURE must be 1..255 and fit in TEN_W bits");
    end

    state_t           state_q, state_d;
    logic             dec_e_q, dec_e_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic [IDX_W-1:0] last_id_q, last_id_d;
    logic [IDX_W:0]   pick;
    logic             timeout;

    assign pick = rr_pick(req, last_id_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);

    logic [TEN_W-1:0] tenure_q, tenure_d, tenure_inc;
    logic             others_req;

    assign tenure_inc = (tenure_q == TEN_MAX) ? TEN_MAX : tenure_q + 1'b1;
    // gnt is the current grantee's one-hot, so masking with it leaves only waiting requesters.
    assign others_req = |(req & ~gnt);
    // Release on the cycle whose count brings tenure to MAX_TENURE, if someone else is waiting.
    assign timeout    = (state_q == GRANT) && (tenure_inc == TEN_MAX) && others_req;

    // Tenure is held at zero outside GRANT so it starts cleared on every grant entry.
    always_comb begin
        tenure_d = '0;
        if (state_q == GRANT) tenure_d = tenure_inc;
    end

    // Tenure counter register.
    always_ff @(posedge clka) begin
        if (!rst_n) tenure_q <= '0;
        else        tenure_q <= tenure_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        dec_e_d   = dec_e_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        case (state_q)
            IDLE: begin
                dec_e_d = 1'b0;
                if (pick[IDX_W]) begin
                    state_d  = GRANT;
                    dec_e_d  = 1'b1;
                    gnt_id_d = pick[IDX_W-1:0];
                end
            end
            GRANT: begin
                if (!req[gnt_id_q] || timeout) begin
                    state_d   = IDLE;
                    dec_e_d   = 1'b0;
                    last_id_d = gnt_id_q;
                end
            end
        endcase
    end

    // State and control registers; last_id resets to 7 so requester 0 has first priority.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dec_e_q   <= 1'b0;
            gnt_id_q  <= '0;
            last_id_q <= IDX_W'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            dec_e_q   <= dec_e_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
        end
    end

    assign dec_e     = dec_e_q;
    assign dec_in    = gnt_id_q;
    assign gnt_valid = dec_e_q;
    assign gnt_id    = gnt_id_q;

    decoder_3_8 u_dec (
        .E   (dec_e),
        .In  (dec_in),
        .Out (gnt)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;

    logic       clka = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       dec_e;
    logic [2:0] dec_in;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_rr_arbiter #(.MAX_TENURE(4), .TEN_W(8)) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .req       (req),
        .dec_e     (dec_e),
        .dec_in    (dec_in),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clka = ~clka;

    task automatic step();
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] e;
        rst_n = 1'b0;
        req   = 8'hFF;
        @(negedge clka);

        // Reset held two cycles with all requests high
        step();
        chk("rst_gnt_c1", gnt, 8'h00);
        step();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_dec_e", {7'b0, dec_e}, 8'h00);
        chk("rst_valid", {7'b0, gnt_valid}, 8'h00);
        chk("rst_gnt_id", {5'b0, gnt_id}, 8'h00);
        chk("rst_dec_in", {5'b0, dec_in}, 8'h00);
        rst_n = 1'b1;
        step();
        chk("rel_gnt", gnt, 8'h01);
        chk("rel_gnt_id", {5'b0, gnt_id}, 8'h00);
        chk("rel_valid", {7'b0, gnt_valid}, 8'h01);

        // Round robin with all requesting: 3 grant cycles, 1 cycle request drop
        for (int k = 0; k < 8; k++) begin
            e = 8'h01 << k;
            step();
            chk($sformatf("rr%0d_c2", k), gnt, e);
            step();
            chk($sformatf("rr%0d_c3", k), gnt, e);
            chk($sformatf("rr%0d_dec_in", k), {5'b0, dec_in}, 8'(k));
            req = 8'hFF & ~e;
            step();
            chk($sformatf("rr%0d_dead", k), gnt, 8'h00);
            chk($sformatf("rr%0d_dead_valid", k), {7'b0, gnt_valid}, 8'h00);
            req = 8'hFF;
            step();
            chk($sformatf("rr%0d_next", k), gnt, 8'h01 << ((k + 1) % 8));
            chk($sformatf("rr%0d_next_id", k), {5'b0, gnt_id}, 8'((k + 1) % 8));
        end

        // Other requesters change during the grant of requester 0
        req = 8'h01;
        step();
        chk("hold_lone", gnt, 8'h01);
        req = 8'h81;
        step();
        chk("hold_add7", gnt, 8'h01);
        req = 8'h11;
        step();
        chk("hold_swap", gnt, 8'h01);

        // Wrap: get last_id=6, then requesters 6 and 0 -> 0 wins
        do_reset();
        req = 8'h40;
        step();
        chk("wrap_g6", gnt, 8'h40);
        chk("wrap_g6_id", {5'b0, gnt_id}, 8'h06);
        req = 8'h00;
        step();
        chk("wrap_dead", gnt, 8'h00);
        step();
        chk("idle_gnt", gnt, 8'h00);
        chk("idle_valid", {7'b0, gnt_valid}, 8'h00);
        chk("idle_gnt_id", {5'b0, gnt_id}, 8'h06);
        req = 8'b0100_0001;
        step();
        chk("wrap_gnt", gnt, 8'h01);
        chk("wrap_gnt_id", {5'b0, gnt_id}, 8'h00);

        // Mid-grant reset while requester 5 holds the grant
        req = 8'h00;
        step();
        req = 8'h20;
        step();
        chk("mr_g5", gnt, 8'h20);
        chk("mr_g5_id", {5'b0, gnt_id}, 8'h05);
        rst_n = 1'b0;
        step();
        chk("mr_rst_gnt", gnt, 8'h00);
        chk("mr_rst_valid", {7'b0, gnt_valid}, 8'h00);
        chk("mr_rst_id", {5'b0, gnt_id}, 8'h00);
        rst_n = 1'b1;
        step();
        chk("mr_regrant", gnt, 8'h20);
        chk("mr_regrant_id", {5'b0, gnt_id}, 8'h05);

`ifdef ARB_TIMEOUT_EN
        // Two requesters held: 4 grant cycles each with one dead cycle between
        do_reset();
        req = 8'h03;
        step();
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("to_p%0d_c%0d", p, c), gnt, (p % 2) ? 8'h02 : 8'h01);
                step();
            end
            chk($sformatf("to_p%0d_dead", p), gnt, 8'h00);
            step();
        end

        // Lone requester keeps its grant and tenure saturates
        do_reset();
        req = 8'h04;
        step();
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("lone_c%0d", c), gnt, 8'h04);
            step();
        end
        chk("lone_tenure", dut.tenure_q, 8'd4);
`else
        // No timeout: requester 0 keeps the grant while requester 1 waits
        do_reset();
        req = 8'h03;
        step();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("nto_c%0d", c), gnt, 8'h01);
            step();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_TENURE, default 15, giving the maximum number of consecutive grant cycles before forced release (range 1..255).
REQ-002 The block SHALL have parameter TEN_W, default 8, giving the tenure counter width in bits.
REQ-003 The block SHALL have port clka, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 8 bits: request lines; bit i belongs to requester i.
REQ-006 The block SHALL have port dec_e, output, 1 bit: enable driven to the 3-to-8 decoder.
REQ-007 The block SHALL have port dec_in, output, 3 bits: select driven to the 3-to-8 decoder.
REQ-008 The block SHALL have port gnt, output, 8 bits: one-hot grant, equal to the decoder output.
REQ-009 The block SHALL have port gnt_valid, output, 1 bit: high while a grant is active.
REQ-010 The block SHALL have port gnt_id, output, 3 bits: index of the current or most recent grantee.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-012 In IDLE with req nonzero, the block SHALL select the first set bit searching upward from (last_id+1) mod 8 and wrap from 7 to 0.
REQ-013 On that selection, the block SHALL register gnt_id, assert dec_e and gnt_valid, and enter GRANT; grant latency is exactly 1 cycle from req sampled.
REQ-014 In IDLE with req zero, dec_e, gnt_valid and gnt SHALL be 0 and the state SHALL not change.
REQ-015 In GRANT, dec_in SHALL equal gnt_id, and gnt SHALL equal 1<<gnt_id when dec_e=1 and 0 otherwise.
REQ-016 In GRANT, when req[gnt_id] is sampled low, the block SHALL deassert dec_e and gnt_valid on the next cycle, set last_id=gnt_id, and return to IDLE, giving exactly one dead cycle between grants.
REQ-017 Requests from other requesters that arrive or drop during GRANT SHALL not disturb the current grant.
REQ-018 The tenure counter SHALL clear on entry to GRANT, increment once per GRANT cycle, and saturate at MAX_TENURE.
REQ-019 When several requesters assert simultaneously in IDLE, only the round-robin winner SHALL be granted; at most one gnt bit is ever set.

Reset
REQ-020 With rst_n low at a clock edge, the block SHALL set state=IDLE, dec_e=0, dec_in=0, gnt=0, gnt_valid=0, gnt_id=0, last_id=7 and tenure=0, so requester 0 holds first priority.
REQ-021 A reset asserted mid-GRANT SHALL drop the grant on the same edge, with no dead-cycle behaviour.

Configuration
REQ-022 With macro ARB_TIMEOUT_EN defined, the block SHALL force release when tenure reaches MAX_TENURE and any other req bit is set, behaving as if req[gnt_id] had dropped (last_id=gnt_id, one dead cycle, IDLE).
REQ-023 With ARB_TIMEOUT_EN defined and no other requester active at tenure MAX_TENURE, the block SHALL keep the grant and keep tenure saturated.
REQ-024 Without ARB_TIMEOUT_EN, the block SHALL hold a grant until req[gnt_id] drops, and the tenure counter SHALL be omitted.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef (IDLE, GRANT), the requester count constant (8) and the index width constant (3).
REQ-026 The block SHALL instantiate the team's existing decoder_3_8 as its single sub-module, mapping E=dec_e, In=dec_in, Out=gnt; the block SHALL not decode separately.

Verification
REQ-027 Reset: rst_n=0 for 2 cycles with req=8'hFF, then release -> gnt=0 during reset; gnt=8'h01 and gnt_id=0 one cycle after release.
REQ-028 Round-robin: req=8'hFF held, each grantee drops its request for 1 cycle after 3 cycles of grant -> grant order 0,1,...,7,0, with one gnt=0 cycle between grants.
REQ-029 Wrap: last_id=6, then req=8'b0100_0001 -> next grant gnt_id=0 (7 empty, wrap to 0), not 6.
REQ-030 Timeout (ARB_TIMEOUT_EN, MAX_TENURE=4): req=8'h03 held -> requester 0 granted 4 cycles, 1 dead cycle, requester 1 granted 4 cycles, alternating.
REQ-031 Timeout with a lone requester (ARB_TIMEOUT_EN): req=8'h04 held 40 cycles -> gnt=8'h04 continuously and tenure stays at MAX_TENURE.
REQ-032 Mid-grant reset: requester 5 granted, rst_n=0 for one edge -> gnt=0 on that edge; after release with req=8'h20 -> gnt=8'h20 after 1 cycle.
